// File: rtl/irig_b_frame_seq.sv
// ---------------------------------------------------------------------------
// irig_b_frame_seq
//
// Frame sequencer for the IRIG-B time-code transmitter. It holds a BCD
// time-of-year written by the host and steps through the 100 symbols of each
// one-second frame. Each 10 ms slot it presents the ASCII code of the symbol
// ("0", "1" or "P") that the downstream drawer turns into the pulse-width
// coded line. The slot counter here is the timing reference for the drawer,
// so both blocks must leave reset on the same clock edge.
//
// Parameters
//   NUM_10MS   last count of one slot; a slot lasts NUM_10MS+1 clocks
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         transmit enable (level)
//   tm_load    one-cycle strobe, captures tm_sec/min/hour/day into the shadow
//   tm_sec     BCD seconds      tens[6:4] units[3:0]
//   tm_min     BCD minutes      tens[6:4] units[3:0]
//   tm_hour    BCD hours        tens[5:4] units[3:0]
//   tm_day     BCD day-of-year  hundreds[9:8] tens[7:4] units[3:0]
//   tm_err     one-cycle pulse, a load was rejected (a digit above 9)
//   sym_code   symbol to draw: 48 "0", 49 "1", 80 "P", 0 when idle
//   sym_idx    index of the current symbol, 0..99
//   sym_stb    pulse on the first clock of every transmitted slot
//   frame_stb  pulse on the first clock of symbol 0
//   stale      frame in flight uses time that was not reloaded since the
//              previous frame start
// ---------------------------------------------------------------------------
module irig_b_frame_seq #(
  parameter logic [31:0] NUM_10MS = 32'd1_249_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        tm_load,
  input  logic [6:0]  tm_sec,
  input  logic [6:0]  tm_min,
  input  logic [5:0]  tm_hour,
  input  logic [9:0]  tm_day,
  output logic        tm_err,
  output logic [31:0] sym_code,
  output logic [6:0]  sym_idx,
  output logic        sym_stb,
  output logic        frame_stb,
  output logic        stale
);

  localparam logic [31:0] CODE_IDLE = 32'd0;
  localparam logic [31:0] CODE_ZERO = 32'd48;
  localparam logic [31:0] CODE_ONE  = 32'd49;
  localparam logic [31:0] CODE_P    = 32'd80;
  localparam logic [6:0]  LAST_IDX  = 7'd99;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] cnt_q, cnt_d;
  logic        boundary;

  logic [6:0]  shadowSec_q, shadowMin_q;
  logic [5:0]  shadowHour_q;
  logic [9:0]  shadowDay_q;

  logic [6:0]  activeSec_q, activeMin_q;
  logic [5:0]  activeHour_q;
  logic [9:0]  activeDay_q;

  logic        loadBad, loadOk;
  logic        tmErr_q;

  logic        lastSym;
  logic        frameStart;
  logic [6:0]  incIdx;
  logic        isMarker;
  logic [99:0] frameBits;

  logic [31:0] symCode_q, symCode_d;
  logic [6:0]  symIdx_q, symIdx_d;
  logic        symStb_q, symStb_d;
  logic        frameStb_q, frameStb_d;
  logic        stale_q, stale_d;
  logic        loadSeen_q, loadSeen_d;

  // Free-running slot counter, independent of the enable.
  assign boundary = (cnt_q == NUM_10MS);

  always_comb begin
    cnt_d = boundary ? 32'd0 : cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Only the 4-bit digit fields can hold a non-BCD value; the 2- and 3-bit
  // tens/hundreds fields are valid by construction.
  assign loadBad = (tm_sec[3:0] > 4'd9) | (tm_min[3:0] > 4'd9) |
                   (tm_hour[3:0] > 4'd9) | (tm_day[3:0] > 4'd9) |
                   (tm_day[7:4] > 4'd9);
  assign loadOk  = tm_load & ~loadBad;

  // Shadow time and the rejection pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadowSec_q  <= 7'd0;
      shadowMin_q  <= 7'd0;
      shadowHour_q <= 6'd0;
      shadowDay_q  <= 10'd0;
      tmErr_q      <= 1'b0;
    end else begin
      tmErr_q <= tm_load & loadBad;
      if (loadOk) begin
        shadowSec_q  <= tm_sec;
        shadowMin_q  <= tm_min;
        shadowHour_q <= tm_hour;
        shadowDay_q  <= tm_day;
      end
    end
  end

  // A frame starts at a boundary either from ARM or by wrapping after index
  // 99 while still enabled.
  assign lastSym    = (symIdx_q == LAST_IDX);
  assign frameStart = boundary & en &
                      ((state_q == ARM) | ((state_q == RUN) & lastSym));

  // The active copy is taken from the registered shadow, so a load landing
  // on the frame-start edge only reaches the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      activeSec_q  <= 7'd0;
      activeMin_q  <= 7'd0;
      activeHour_q <= 6'd0;
      activeDay_q  <= 10'd0;
    end else if (frameStart) begin
      activeSec_q  <= shadowSec_q;
      activeMin_q  <= shadowMin_q;
      activeHour_q <= shadowHour_q;
      activeDay_q  <= shadowDay_q;
    end
  end

  // Data bits of the frame laid out by symbol index, LSB of each digit first.
  always_comb begin
    frameBits        = '0;
    frameBits[4:1]   = activeSec_q[3:0];
    frameBits[8:6]   = activeSec_q[6:4];
    frameBits[13:10] = activeMin_q[3:0];
    frameBits[17:15] = activeMin_q[6:4];
    frameBits[23:20] = activeHour_q[3:0];
    frameBits[26:25] = activeHour_q[5:4];
    frameBits[33:30] = activeDay_q[3:0];
    frameBits[38:35] = activeDay_q[7:4];
    frameBits[41:40] = activeDay_q[9:8];
  end

  // Position markers for the symbol about to be sent. Index 0 never goes
  // through this path because frame start forces "P" directly.
  assign incIdx = symIdx_q + 7'd1;

  always_comb begin
    isMarker = 1'b0;
    case (incIdx)
      7'd9, 7'd19, 7'd29, 7'd39, 7'd49,
      7'd59, 7'd69, 7'd79, 7'd89, 7'd99: isMarker = 1'b1;
      default:                           isMarker = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A running frame always completes; only ARM reacts to
  // the enable falling.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) state_d = ARM;
      end
      ARM: begin
        if (!en)          state_d = IDLE;
        else if (boundary) state_d = RUN;
      end
      RUN: begin
        if (boundary && lastSym && !en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic, producing next values for the registered outputs so that
  // everything changes on the boundary edge and holds for the whole slot.
  always_comb begin
    symCode_d  = symCode_q;
    symIdx_d   = symIdx_q;
    symStb_d   = 1'b0;
    frameStb_d = 1'b0;
    stale_d    = stale_q;
    loadSeen_d = loadSeen_q | loadOk;

    if (frameStart) begin
      symCode_d  = CODE_P;
      symIdx_d   = 7'd0;
      symStb_d   = 1'b1;
      frameStb_d = 1'b1;
      stale_d    = ~loadSeen_q;
      loadSeen_d = loadOk;
    end else if ((state_q == RUN) && boundary) begin
      if (lastSym) begin
        symCode_d = CODE_IDLE;
        symIdx_d  = 7'd0;
      end else begin
        symIdx_d  = incIdx;
        symStb_d  = 1'b1;
        if (isMarker)               symCode_d = CODE_P;
        else if (frameBits[incIdx]) symCode_d = CODE_ONE;
        else                        symCode_d = CODE_ZERO;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      symCode_q  <= CODE_IDLE;
      symIdx_q   <= 7'd0;
      symStb_q   <= 1'b0;
      frameStb_q <= 1'b0;
      stale_q    <= 1'b0;
      loadSeen_q <= 1'b0;
    end else begin
      symCode_q  <= symCode_d;
      symIdx_q   <= symIdx_d;
      symStb_q   <= symStb_d;
      frameStb_q <= frameStb_d;
      stale_q    <= stale_d;
      loadSeen_q <= loadSeen_d;
    end
  end

  assign tm_err    = tmErr_q;
  assign sym_code  = symCode_q;
  assign sym_idx   = symIdx_q;
  assign sym_stb   = symStb_q;
  assign frame_stb = frameStb_q;
  assign stale     = stale_q;

endmodule

// File: tb/tb_irig_b_frame_seq.sv
// ---------------------------------------------------------------------------
// tb_irig_b_frame_seq
//
// Bench for irig_b_frame_seq with 10-clock slots. Expected symbol codes are
// generated from the time values the bench loads and queued up front; each
// scenario task pops and compares them as the DUT strobes out its slots.
// ---------------------------------------------------------------------------
module tb_irig_b_frame_seq;

   localparam logic [31:0] NUM = 32'd9;
   localparam int SLOT = 10;

   logic        clock = 1'b0;
   logic        reset;
   logic        en;
   logic        tmLoad;
   logic [6:0]  tmSec;
   logic [6:0]  tmMin;
   logic [5:0]  tmHour;
   logic [9:0]  tmDay;
   logic        tmErr;
   logic [31:0] symCode;
   logic [6:0]  symIdx;
   logic        symStb;
   logic        frameStb;
   logic        stale;

   int total = 0;
   int bad = 0;
   int expQ[$];

   irig_b_frame_seq #(.NUM_10MS(NUM)) dut (
      .clk       (clock),
      .rst       (reset),
      .en        (en),
      .tm_load   (tmLoad),
      .tm_sec    (tmSec),
      .tm_min    (tmMin),
      .tm_hour   (tmHour),
      .tm_day    (tmDay),
      .tm_err    (tmErr),
      .sym_code  (symCode),
      .sym_idx   (symIdx),
      .sym_stb   (symStb),
      .frame_stb (frameStb),
      .stale     (stale)
   );

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   // Reference symbol for one index, built from a table of digit fields.
   function automatic int expCode(input int idx, input logic [6:0] s,
                                  input logic [6:0] m, input logic [5:0] h,
                                  input logic [9:0] d);
      int base[9];
      int width[9];
      int val[9];
      base  = '{1, 6, 10, 15, 20, 25, 30, 35, 40};
      width = '{4, 3, 4, 3, 4, 2, 4, 4, 2};
      val   = '{int'(s[3:0]), int'(s[6:4]), int'(m[3:0]), int'(m[6:4]),
                int'(h[3:0]), int'(h[5:4]), int'(d[3:0]), int'(d[7:4]),
                int'(d[9:8])};
      if (idx == 0 || (idx % 10) == 9) return 80;
      for (int g = 0; g < 9; g++) begin
         if (idx >= base[g] && idx < base[g] + width[g])
            return (((val[g] >> (idx - base[g])) & 1) == 1) ? 49 : 48;
      end
      return 48;
   endfunction

   // Queue the 100 expected codes of one frame.
   task automatic pushFrame(input logic [6:0] s, input logic [6:0] m,
                            input logic [5:0] h, input logic [9:0] d);
      for (int i = 0; i < 100; i++) expQ.push_back(expCode(i, s, m, h, d));
   endtask

   // Drive a one-cycle load strobe without consuming a sampling edge.
   task automatic applyStimulus(input logic [6:0] s, input logic [6:0] m,
                                input logic [5:0] h, input logic [9:0] d);
      tmSec  = s;
      tmMin  = m;
      tmHour = h;
      tmDay  = d;
      tmLoad = 1'b1;
      fork
         begin
            @(posedge clock);
            #1 tmLoad = 1'b0;
         end
      join_none
   endtask

   // Advance to the next slot strobe with a bounded wait.
   task automatic waitSlot(output bit timedOut);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!symStb && n < 3 * SLOT);
      timedOut = !symStb;
   endtask

   // Sample the rest of a slot: code steady, strobes low, count tm_err.
   task automatic watchHold(input int code, output bit steady,
                            output bit errFirst, output int errCount);
      steady = 1'b1;
      errFirst = 1'b0;
      errCount = 0;
      for (int k = 0; k < SLOT - 1; k++) begin
         @(negedge clock);
         if (symCode !== code || symStb !== 1'b0 || frameStb !== 1'b0) steady = 1'b0;
         if (tmErr === 1'b1) begin
            errCount++;
            if (k == 0) errFirst = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en = 1'b0;
      tmLoad = 1'b0;
      tmSec = '0;
      tmMin = '0;
      tmHour = '0;
      tmDay = '0;
      repeat (3) @(negedge clock);
      total++; if (symCode !== 32'd0) begin bad++; $display("[TB] FAIL reset_sym_code got=%0d want=0", symCode); end
      total++; if (symIdx !== 7'd0) begin bad++; $display("[TB] FAIL reset_sym_idx got=%0d want=0", symIdx); end
      total++; if (symStb !== 1'b0) begin bad++; $display("[TB] FAIL reset_sym_stb got=%b want=0", symStb); end
      total++; if (frameStb !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_stb got=%b want=0", frameStb); end
      total++; if (tmErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_tm_err got=%b want=0", tmErr); end
      total++; if (stale !== 1'b0) begin bad++; $display("[TB] FAIL reset_stale got=%b want=0", stale); end
      reset = 1'b0;
   endtask

   // Enable with no load; drop the enable at index 40 and expect the frame
   // to run out to 99 before the line goes idle.
   task automatic test_no_load();
      int n;
      int exp;
      bit to, steady, ef;
      int ec;
      en = 1'b1;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!frameStb && n < 3 * SLOT);
      total++;
      if (frameStb !== 1'b1 || n != SLOT) begin
         bad++; $display("[TB] FAIL first_frame_latency got=%0d cycles want=%0d", n, SLOT);
      end
      total++; if (stale !== 1'b1) begin bad++; $display("[TB] FAIL stale_no_load got=%b want=1", stale); end
      pushFrame(7'h00, 7'h00, 6'h00, 10'h000);
      for (int i = 0; i < 100; i++) begin
         if (i > 0) waitSlot(to); else to = 1'b0;
         exp = expQ.pop_front();
         total++;
         if (to || symCode !== exp || symIdx !== 7'(i)) begin
            bad++; $display("[TB] FAIL noload_slot%0d got code=%0d idx=%0d want code=%0d idx=%0d", i, symCode, symIdx, exp, i);
         end
         if (i == 40) en = 1'b0;
         watchHold(exp, steady, ef, ec);
         total++; if (!steady) begin bad++; $display("[TB] FAIL noload_hold%0d got unsteady want steady code=%0d", i, exp); end
      end
      @(negedge clock);
      total++;
      if (symCode !== 32'd0 || symIdx !== 7'd0 || symStb !== 1'b0) begin
         bad++; $display("[TB] FAIL idle_after_frame got code=%0d idx=%0d stb=%b want 0/0/0", symCode, symIdx, symStb);
      end
   endtask

   // Enable for a few cycles inside one slot and drop it again before the
   // boundary: nothing may be transmitted.
   task automatic test_arm_cancel();
      bit seen;
      @(negedge clock);
      en = 1'b1;
      repeat (3) @(negedge clock);
      en = 1'b0;
      seen = 1'b0;
      repeat (3 * SLOT) begin
         @(negedge clock);
         if (frameStb !== 1'b0 || symStb !== 1'b0 || symCode !== 32'd0) seen = 1'b1;
      end
      total++; if (seen) begin bad++; $display("[TB] FAIL arm_cancel got activity want none"); end
   endtask

   // Load and enable in the same cycle; the first frame carries the time.
   task automatic test_load_frame();
      int exp;
      bit to, steady, ef;
      int ec;
      applyStimulus(7'h59, 7'h34, 6'h12, 10'h365);
      en = 1'b1;
      pushFrame(7'h59, 7'h34, 6'h12, 10'h365);
      for (int i = 0; i < 100; i++) begin
         waitSlot(to);
         exp = expQ.pop_front();
         total++;
         if (to || symCode !== exp || symIdx !== 7'(i)) begin
            bad++; $display("[TB] FAIL load_slot%0d got code=%0d idx=%0d want code=%0d idx=%0d", i, symCode, symIdx, exp, i);
         end
         if (i == 0) begin
            total++; if (frameStb !== 1'b1) begin bad++; $display("[TB] FAIL load_frame_stb got=%b want=1", frameStb); end
            total++; if (stale !== 1'b0) begin bad++; $display("[TB] FAIL load_stale got=%b want=0", stale); end
         end
         watchHold(exp, steady, ef, ec);
         total++; if (!steady) begin bad++; $display("[TB] FAIL load_hold%0d got unsteady want steady", i); end
      end
   endtask

   // A non-BCD load mid-frame is rejected with a single tm_err pulse; the
   // following frame keeps the old time and is flagged stale.
   task automatic test_bad_load();
      int exp;
      bit to, steady, ef;
      int ec;
      pushFrame(7'h59, 7'h34, 6'h12, 10'h365);
      for (int i = 0; i < 100; i++) begin
         waitSlot(to);
         exp = expQ.pop_front();
         total++;
         if (to || symCode !== exp || symIdx !== 7'(i)) begin
            bad++; $display("[TB] FAIL bad_slot%0d got code=%0d idx=%0d want code=%0d idx=%0d", i, symCode, symIdx, exp, i);
         end
         if (i == 0) begin
            total++; if (stale !== 1'b1) begin bad++; $display("[TB] FAIL bad_stale got=%b want=1", stale); end
         end
         if (i == 5) applyStimulus(7'h5A, 7'h11, 6'h01, 10'h001);
         watchHold(exp, steady, ef, ec);
         total++; if (!steady) begin bad++; $display("[TB] FAIL bad_hold%0d got unsteady want steady", i); end
         if (i == 5) begin
            total++;
            if (!ef || ec != 1) begin
               bad++; $display("[TB] FAIL tm_err_pulse got first=%b count=%0d want first=1 count=1", ef, ec);
            end
         end
      end
   endtask

   // Load on the exact frame-start boundary: the next frame keeps the old
   // time, the one after carries the new time. Stops at index 55.
   task automatic test_collision();
      int exp;
      int idx;
      bit to, steady, ef;
      int ec;
      applyStimulus(7'h07, 7'h58, 6'h23, 10'h129);
      pushFrame(7'h59, 7'h34, 6'h12, 10'h365);
      pushFrame(7'h07, 7'h58, 6'h23, 10'h129);
      for (int i = 0; i < 156; i++) begin
         idx = i % 100;
         waitSlot(to);
         exp = expQ.pop_front();
         total++;
         if (to || symCode !== exp || symIdx !== 7'(idx)) begin
            bad++; $display("[TB] FAIL coll_slot%0d got code=%0d idx=%0d want code=%0d idx=%0d", i, symCode, symIdx, exp, idx);
         end
         if (i == 0) begin
            total++; if (stale !== 1'b1) begin bad++; $display("[TB] FAIL coll_stale_old got=%b want=1", stale); end
         end
         if (i == 100) begin
            total++; if (stale !== 1'b0) begin bad++; $display("[TB] FAIL coll_stale_new got=%b want=0", stale); end
         end
         if (i == 155) break;
         watchHold(exp, steady, ef, ec);
         total++; if (!steady) begin bad++; $display("[TB] FAIL coll_hold%0d got unsteady want steady", i); end
      end
      expQ.delete();
   endtask

   // Reset at index 55 for three cycles, then framing restarts on the grid.
   task automatic test_reset_mid();
      int n;
      int exp;
      bit to, steady, ef;
      int ec;
      #1 reset = 1'b1;
      #1;
      total++; if (symCode !== 32'd0) begin bad++; $display("[TB] FAIL midrst_code got=%0d want=0", symCode); end
      total++; if (symIdx !== 7'd0) begin bad++; $display("[TB] FAIL midrst_idx got=%0d want=0", symIdx); end
      total++; if (stale !== 1'b0) begin bad++; $display("[TB] FAIL midrst_stale got=%b want=0", stale); end
      total++; if (symStb !== 1'b0 || frameStb !== 1'b0 || tmErr !== 1'b0) begin
         bad++; $display("[TB] FAIL midrst_strobes got=%b%b%b want=000", symStb, frameStb, tmErr);
      end
      repeat (3) @(negedge clock);
      reset = 1'b0;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!frameStb && n < 3 * SLOT);
      total++;
      if (frameStb !== 1'b1 || n != SLOT || symIdx !== 7'd0 || symCode !== 32'd80) begin
         bad++; $display("[TB] FAIL restart got cycles=%0d idx=%0d code=%0d want cycles=%0d idx=0 code=80", n, symIdx, symCode, SLOT);
      end
      total++; if (stale !== 1'b1) begin bad++; $display("[TB] FAIL restart_stale got=%b want=1", stale); end
      pushFrame(7'h00, 7'h00, 6'h00, 10'h000);
      for (int i = 0; i < 12; i++) begin
         if (i > 0) begin
            waitSlot(to);
            exp = expQ.pop_front();
            total++;
            if (to || symCode !== exp || symIdx !== 7'(i)) begin
               bad++; $display("[TB] FAIL restart_slot%0d got code=%0d idx=%0d want code=%0d idx=%0d", i, symCode, symIdx, exp, i);
            end
         end else begin
            exp = expQ.pop_front();
         end
         watchHold(exp, steady, ef, ec);
         total++; if (!steady) begin bad++; $display("[TB] FAIL restart_hold%0d got unsteady want steady", i); end
      end
      en = 1'b0;
      expQ.delete();
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_no_load();
      test_arm_cancel();
      test_load_frame();
      test_bad_load();
      test_collision();
      test_reset_mid();
      repeat (5) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
